// File: rtl/note_lane_scroller_pkg.sv
// Shared screen geometry and timing constants for the falling-note lane scroller.
// Also provides a ceiling-log2 helper for sizing index fields.
package note_lane_scroller_pkg;

    localparam int Y_W      = 10;
    localparam int SCREEN_H = 480;
    localparam int LANE_W   = 160;
    localparam int NOTE_H   = 16;
    localparam int HIT_Y    = 440;
    localparam int HIT_WIN  = 16;

    // Never returns less than 1, so an index field is always at least one bit wide.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/note_lane_scroller_if.sv
// Sequencer/VGA-side bus of the note lane scroller: spawn handshake, strikes, events, pixel query.
interface note_lane_scroller_if import note_lane_scroller_pkg::*; #(
    parameter int NUM_LANES = 4
) ();
    localparam int LW = clog2(NUM_LANES);

    logic                 frame_tick;
    logic                 spawn_valid;
    logic [NUM_LANES-1:0] spawn_lanes;
    logic                 spawn_ready;
    logic [NUM_LANES-1:0] hit;
    logic [NUM_LANES-1:0] hit_ok;
    logic [NUM_LANES-1:0] hit_bad;
    logic [NUM_LANES-1:0] miss;
    logic [15:0]          score;
    logic [Y_W-1:0]       pix_x;
    logic [Y_W-1:0]       pix_y;
    logic                 pix_on;
    logic [LW-1:0]        pix_lane;

    modport master (
        output frame_tick, spawn_valid, spawn_lanes, hit, pix_x, pix_y,
        input  spawn_ready, hit_ok, hit_bad, miss, score, pix_on, pix_lane
    );

    modport slave (
        input  frame_tick, spawn_valid, spawn_lanes, hit, pix_x, pix_y,
        output spawn_ready, hit_ok, hit_bad, miss, score, pix_on, pix_lane
    );
endinterface

// File: rtl/note_lane_scroller_lane.sv
// One lane of SLOTS falling notes: spawn into lowest free slot, per-frame advance with retirement,
// strike search for the lowest-on-screen note in the hit window, and a pixel row cover test.
module note_lane import note_lane_scroller_pkg::*; #(
    parameter int SLOTS = 4,
    parameter int SPEED = 2
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_frame_tick,
    input  logic           i_spawn,
    input  logic           i_hit,
    input  logic [Y_W-1:0] i_pix_y,
    output logic           o_has_free,
    output logic           o_hit_ok,
    output logic           o_hit_bad,
    output logic           o_retire,
    output logic           o_cover
);
    localparam int SW = clog2(SLOTS);
    localparam logic [Y_W:0] WIN_LO  = (Y_W+1)'(HIT_Y - HIT_WIN);
    localparam logic [Y_W:0] WIN_HI  = (Y_W+1)'(HIT_Y + HIT_WIN);
    localparam logic [Y_W:0] LIMIT   = (Y_W+1)'(SCREEN_H);
    localparam logic [Y_W:0] HEIGHT  = (Y_W+1)'(NOTE_H);
    localparam logic [Y_W:0] STEP    = (Y_W+1)'(SPEED);

    logic [SLOTS-1:0] r_valid;
    logic [Y_W-1:0]   r_y [SLOTS];

    logic [SLOTS-1:0] w_valid_nxt;
    logic [Y_W-1:0]   w_y_nxt [SLOTS];
    logic [Y_W:0]     w_sum [SLOTS];
    logic [SLOTS-1:0] w_retire_vec;
    logic [SW-1:0]    w_free_idx;
    logic [SW-1:0]    w_hit_idx;
    logic             w_found;
    logic [Y_W-1:0]   w_best_y;

    always_comb begin
        o_has_free = 1'b0;
        w_free_idx = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (!r_valid[s]) begin
                o_has_free = 1'b1;
                w_free_idx = SW'(s);
            end
        end
    end

    // Strict '>' keeps the lowest slot index when two candidates share the same y.
    always_comb begin
        w_found   = 1'b0;
        w_hit_idx = '0;
        w_best_y  = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (r_valid[s] && ({1'b0, r_y[s]} >= WIN_LO) && ({1'b0, r_y[s]} <= WIN_HI) &&
                (!w_found || (r_y[s] > w_best_y))) begin
                w_found   = 1'b1;
                w_hit_idx = SW'(s);
                w_best_y  = r_y[s];
            end
        end
    end

    // Per slot: strike clear wins over spawn, spawn wins over frame advance.
    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            w_sum[s]        = {1'b0, r_y[s]} + STEP;
            w_valid_nxt[s]  = r_valid[s];
            w_y_nxt[s]      = r_y[s];
            w_retire_vec[s] = 1'b0;
            if (i_hit && w_found && (w_hit_idx == SW'(s))) begin
                w_valid_nxt[s] = 1'b0;
            end else if (i_spawn && !r_valid[s] && (w_free_idx == SW'(s))) begin
                w_valid_nxt[s] = 1'b1;
                w_y_nxt[s]     = '0;
            end else if (i_frame_tick && r_valid[s]) begin
                if (w_sum[s] >= LIMIT) begin
                    w_valid_nxt[s]  = 1'b0;
                    w_retire_vec[s] = 1'b1;
                end else begin
                    w_y_nxt[s] = w_sum[s][Y_W-1:0];
                end
            end
        end
    end

    always_comb begin
        o_cover = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            if (r_valid[s] && ({1'b0, r_y[s]} <= {1'b0, i_pix_y}) &&
                ({1'b0, i_pix_y} < ({1'b0, r_y[s]} + HEIGHT))) begin
                o_cover = 1'b1;
            end
        end
    end

    assign o_hit_ok  = i_hit & w_found;
    assign o_hit_bad = i_hit & ~w_found;
    assign o_retire  = |w_retire_vec;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            for (int s = 0; s < SLOTS; s++) r_y[s] <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            for (int s = 0; s < SLOTS; s++) r_y[s] <= w_y_nxt[s];
        end
    end

endmodule

// File: rtl/note_lane_scroller.sv
// Multi-lane falling-note tracker: spawn gating across lanes, event/score registers and the
// one-cycle pixel cover lookup feeding the VGA colour mux.
module note_lane_scroller import note_lane_scroller_pkg::*; #(
    parameter int          NUM_LANES  = 4,
    parameter int          SLOTS      = 4,
    parameter int          SPEED      = 2,
    parameter logic [15:0] SCORE_INIT = 16'h0000
) (
    input logic                  CLOCK_25,
    input logic                  reset_n,
    note_lane_scroller_if.slave  bus
);
    localparam int LW = clog2(NUM_LANES);

    logic [NUM_LANES-1:0] w_free;
    logic [NUM_LANES-1:0] w_hit_ok;
    logic [NUM_LANES-1:0] w_hit_bad;
    logic [NUM_LANES-1:0] w_retire;
    logic [NUM_LANES-1:0] w_cover;
    logic                 w_accept;
    logic [LW:0]          w_nhit;
    logic [LW-1:0]        w_lane;
    logic                 w_in_lane;

    logic [NUM_LANES-1:0] r_hit_ok;
    logic [NUM_LANES-1:0] r_hit_bad;
    logic [NUM_LANES-1:0] r_miss;
    logic [15:0]          r_score;
    logic                 r_pix_on;
    logic [LW-1:0]        r_pix_lane;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [LW:0] n);
        logic [16:0] s;
        s = {1'b0, a} + 17'(n);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        note_lane #(.SLOTS(SLOTS), .SPEED(SPEED)) u_lane (
            .i_clk        (CLOCK_25),
            .i_rst_n      (reset_n),
            .i_frame_tick (bus.frame_tick),
            .i_spawn      (w_accept & bus.spawn_lanes[l]),
            .i_hit        (bus.hit[l]),
            .i_pix_y      (bus.pix_y),
            .o_has_free   (w_free[l]),
            .o_hit_ok     (w_hit_ok[l]),
            .o_hit_bad    (w_hit_bad[l]),
            .o_retire     (w_retire[l]),
            .o_cover      (w_cover[l])
        );
    end

    // A request is all-or-nothing: every masked lane must have room.
    assign bus.spawn_ready = reset_n & (&(~bus.spawn_lanes | w_free));
    assign w_accept        = bus.spawn_valid & bus.spawn_ready;

    always_comb begin
        w_nhit = '0;
        for (int l = 0; l < NUM_LANES; l++) w_nhit = w_nhit + (LW+1)'(w_hit_ok[l]);
    end

    // Lane decode by range comparison; columns right of the last lane match nothing.
    always_comb begin
        w_lane    = '0;
        w_in_lane = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (({1'b0, bus.pix_x} >= (Y_W+1)'(l * LANE_W)) &&
                ({1'b0, bus.pix_x} <  (Y_W+1)'((l + 1) * LANE_W))) begin
                w_lane    = LW'(l);
                w_in_lane = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_ok   <= '0;
            r_hit_bad  <= '0;
            r_miss     <= '0;
            r_score    <= SCORE_INIT;
            r_pix_on   <= 1'b0;
            r_pix_lane <= '0;
        end else begin
            r_hit_ok   <= w_hit_ok;
            r_hit_bad  <= w_hit_bad;
            r_miss     <= w_retire;
            r_score    <= sat_add(r_score, w_nhit);
            r_pix_on   <= w_in_lane & w_cover[w_lane];
            r_pix_lane <= (w_in_lane & w_cover[w_lane]) ? w_lane : '0;
        end
    end

    assign bus.hit_ok   = r_hit_ok;
    assign bus.hit_bad  = r_hit_bad;
    assign bus.miss     = r_miss;
    assign bus.score    = r_score;
    assign bus.pix_on   = r_pix_on;
    assign bus.pix_lane = r_pix_lane;

endmodule

// File: tb/tb_note_lane_scroller.sv
// Directed bench for note_lane_scroller; a second instance with a preloaded score covers saturation.
module tb_note_lane_scroller;
    import note_lane_scroller_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #20 clk = ~clk;

    note_lane_scroller_if #(.NUM_LANES(4)) bus ();
    note_lane_scroller_if #(.NUM_LANES(4)) bus2 ();

    assign bus2.frame_tick  = bus.frame_tick;
    assign bus2.spawn_valid = bus.spawn_valid;
    assign bus2.spawn_lanes = bus.spawn_lanes;
    assign bus2.hit         = bus.hit;
    assign bus2.pix_x       = bus.pix_x;
    assign bus2.pix_y       = bus.pix_y;

    note_lane_scroller #(.NUM_LANES(4), .SLOTS(4), .SPEED(2), .SCORE_INIT(16'h0000)) dut (
        .CLOCK_25 (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    note_lane_scroller #(.NUM_LANES(4), .SLOTS(4), .SPEED(2), .SCORE_INIT(16'hFFFD)) dut_sat (
        .CLOCK_25 (clk),
        .reset_n  (rst_n),
        .bus      (bus2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.frame_tick  = 1'b0;
        bus.spawn_valid = 1'b0;
        bus.spawn_lanes = 4'b0000;
        bus.hit         = 4'b0000;
        bus.pix_x       = '0;
        bus.pix_y       = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic spawn(input logic [3:0] m);
        bus.spawn_valid = 1'b1;
        bus.spawn_lanes = m;
        step();
        bus.spawn_valid = 1'b0;
        bus.spawn_lanes = 4'b0000;
    endtask

    task automatic frames(input int n);
        bus.frame_tick = 1'b1;
        repeat (n) step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic strike(input logic [3:0] m);
        bus.hit = m;
        step();
        bus.hit = 4'b0000;
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y);
        bus.pix_x = x;
        bus.pix_y = y;
        step();
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.spawn_valid = 1'b1;
        bus.spawn_lanes = 4'b0001;
        bus.hit         = 4'b1111;
        bus.frame_tick  = 1'b1;
        bus.pix_x       = 10'd10;
        bus.pix_y       = 10'd0;
        repeat (3) step();
        n_cmp++; if (bus.spawn_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", bus.spawn_ready); end
        n_cmp++; if (bus.hit_ok !== 4'b0000) begin n_bad++; $display("FAIL rst_hit_ok got %b want 0000", bus.hit_ok); end
        n_cmp++; if (bus.hit_bad !== 4'b0000) begin n_bad++; $display("FAIL rst_hit_bad got %b want 0000", bus.hit_bad); end
        n_cmp++; if (bus.miss !== 4'b0000) begin n_bad++; $display("FAIL rst_miss got %b want 0000", bus.miss); end
        n_cmp++; if (bus.score !== 16'h0000) begin n_bad++; $display("FAIL rst_score got %h want 0000", bus.score); end
        n_cmp++; if (bus.pix_on !== 1'b0) begin n_bad++; $display("FAIL rst_pix_on got %b want 0", bus.pix_on); end
        n_cmp++; if (bus.pix_lane !== 2'd0) begin n_bad++; $display("FAIL rst_pix_lane got %0d want 0", bus.pix_lane); end
        n_cmp++; if (bus2.score !== 16'hFFFD) begin n_bad++; $display("FAIL rst_score_init got %h want fffd", bus2.score); end
        clear_inputs();
        bus.spawn_lanes = 4'b0001;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.spawn_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready got %b want 1", bus.spawn_ready); end
        bus.spawn_lanes = 4'b0000;
        step();
    endtask

    task automatic test_spawn_pixel();
        do_reset();
        spawn(4'b0101);
        frames(3);
        probe(10'd10, 10'd6);
        n_cmp++; if (bus.pix_on !== 1'b1) begin n_bad++; $display("FAIL pix_10_6_on got %b want 1", bus.pix_on); end
        n_cmp++; if (bus.pix_lane !== 2'd0) begin n_bad++; $display("FAIL pix_10_6_lane got %0d want 0", bus.pix_lane); end
        probe(10'd10, 10'd22);
        n_cmp++; if (bus.pix_on !== 1'b0) begin n_bad++; $display("FAIL pix_10_22_on got %b want 0", bus.pix_on); end
        probe(10'd10, 10'd5);
        n_cmp++; if (bus.pix_on !== 1'b0) begin n_bad++; $display("FAIL pix_10_5_on got %b want 0", bus.pix_on); end
        probe(10'd170, 10'd6);
        n_cmp++; if (bus.pix_on !== 1'b0) begin n_bad++; $display("FAIL pix_170_6_on got %b want 0", bus.pix_on); end
        n_cmp++; if (bus.pix_lane !== 2'd0) begin n_bad++; $display("FAIL pix_170_6_lane got %0d want 0", bus.pix_lane); end
        probe(10'd330, 10'd21);
        n_cmp++; if (bus.pix_on !== 1'b1) begin n_bad++; $display("FAIL pix_330_21_on got %b want 1", bus.pix_on); end
        n_cmp++; if (bus.pix_lane !== 2'd2) begin n_bad++; $display("FAIL pix_330_21_lane got %0d want 2", bus.pix_lane); end
        probe(10'd650, 10'd6);
        n_cmp++; if (bus.pix_on !== 1'b0) begin n_bad++; $display("FAIL pix_650_on got %b want 0", bus.pix_on); end
    endtask

    task automatic test_fill();
        do_reset();
        spawn(4'b0001);
        bus.spawn_valid = 1'b1;
        bus.spawn_lanes = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (bus.spawn_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_%0d got %b want 1", i, bus.spawn_ready); end
            step();
        end
        bus.spawn_lanes = 4'b0011;
        #1;
        n_cmp++; if (bus.spawn_ready !== 1'b0) begin n_bad++; $display("FAIL full_0011_ready got %b want 0", bus.spawn_ready); end
        bus.spawn_lanes = 4'b0100;
        #1;
        n_cmp++; if (bus.spawn_ready !== 1'b1) begin n_bad++; $display("FAIL free_0100_ready got %b want 1", bus.spawn_ready); end
        bus.spawn_lanes = 4'b0011;
        step();
        bus.spawn_lanes = 4'b0000;
        #1;
        n_cmp++; if (bus.spawn_ready !== 1'b1) begin n_bad++; $display("FAIL empty_mask_ready got %b want 1", bus.spawn_ready); end
        step();
        bus.spawn_lanes = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (bus.spawn_ready !== 1'b1) begin n_bad++; $display("FAIL lane0_room_%0d got %b want 1", i, bus.spawn_ready); end
            step();
        end
        #1;
        n_cmp++; if (bus.spawn_ready !== 1'b0) begin n_bad++; $display("FAIL lane0_full_ready got %b want 0", bus.spawn_ready); end
        bus.spawn_valid = 1'b0;
        bus.spawn_lanes = 4'b0000;
        probe(10'd170, 10'd0);
        n_cmp++; if (bus.pix_on !== 1'b1) begin n_bad++; $display("FAIL lane1_pix_on got %b want 1", bus.pix_on); end
        n_cmp++; if (bus.pix_lane !== 2'd1) begin n_bad++; $display("FAIL lane1_pix_lane got %0d want 1", bus.pix_lane); end
    endtask

    task automatic test_hit();
        do_reset();
        spawn(4'b0001);
        frames(8);
        spawn(4'b0001);
        frames(212);
        strike(4'b0001);
        n_cmp++; if (bus.hit_ok !== 4'b0001) begin n_bad++; $display("FAIL hit1_ok got %b want 0001", bus.hit_ok); end
        n_cmp++; if (bus.hit_bad !== 4'b0000) begin n_bad++; $display("FAIL hit1_bad got %b want 0000", bus.hit_bad); end
        n_cmp++; if (bus.score !== 16'd1) begin n_bad++; $display("FAIL hit1_score got %0d want 1", bus.score); end
        step();
        n_cmp++; if (bus.hit_ok !== 4'b0000) begin n_bad++; $display("FAIL hit1_pulse got %b want 0000", bus.hit_ok); end
        probe(10'd10, 10'd445);
        n_cmp++; if (bus.pix_on !== 1'b0) begin n_bad++; $display("FAIL hit_lowest_gone got %b want 0", bus.pix_on); end
        probe(10'd10, 10'd430);
        n_cmp++; if (bus.pix_on !== 1'b1) begin n_bad++; $display("FAIL hit_upper_kept got %b want 1", bus.pix_on); end
        strike(4'b0001);
        n_cmp++; if (bus.hit_ok !== 4'b0001) begin n_bad++; $display("FAIL hit2_ok got %b want 0001", bus.hit_ok); end
        n_cmp++; if (bus.score !== 16'd2) begin n_bad++; $display("FAIL hit2_score got %0d want 2", bus.score); end
        strike(4'b0001);
        n_cmp++; if (bus.hit_bad !== 4'b0001) begin n_bad++; $display("FAIL hit3_bad got %b want 0001", bus.hit_bad); end
        n_cmp++; if (bus.hit_ok !== 4'b0000) begin n_bad++; $display("FAIL hit3_ok got %b want 0000", bus.hit_ok); end
        n_cmp++; if (bus.score !== 16'd2) begin n_bad++; $display("FAIL hit3_score got %0d want 2", bus.score); end
        step();
        n_cmp++; if (bus.hit_bad !== 4'b0000) begin n_bad++; $display("FAIL hit3_pulse got %b want 0000", bus.hit_bad); end
    endtask

    task automatic test_window();
        do_reset();
        spawn(4'b0111);
        frames(211);
        strike(4'b0001);
        n_cmp++; if (bus.hit_bad !== 4'b0001) begin n_bad++; $display("FAIL win_422_bad got %b want 0001", bus.hit_bad); end
        frames(1);
        strike(4'b0001);
        n_cmp++; if (bus.hit_ok !== 4'b0001) begin n_bad++; $display("FAIL win_424_ok got %b want 0001", bus.hit_ok); end
        n_cmp++; if (bus.score !== 16'd1) begin n_bad++; $display("FAIL win_424_score got %0d want 1", bus.score); end
        frames(16);
        strike(4'b0010);
        n_cmp++; if (bus.hit_ok !== 4'b0010) begin n_bad++; $display("FAIL win_456_ok got %b want 0010", bus.hit_ok); end
        frames(1);
        strike(4'b0100);
        n_cmp++; if (bus.hit_bad !== 4'b0100) begin n_bad++; $display("FAIL win_458_bad got %b want 0100", bus.hit_bad); end
        n_cmp++; if (bus.score !== 16'd2) begin n_bad++; $display("FAIL win_458_score got %0d want 2", bus.score); end
    endtask

    task automatic test_miss();
        do_reset();
        spawn(4'b0001);
        frames(239);
        n_cmp++; if (bus.miss !== 4'b0000) begin n_bad++; $display("FAIL miss_early got %b want 0000", bus.miss); end
        bus.frame_tick  = 1'b1;
        bus.spawn_valid = 1'b1;
        bus.spawn_lanes = 4'b0001;
        #1;
        n_cmp++; if (bus.spawn_ready !== 1'b1) begin n_bad++; $display("FAIL miss_spawn_ready got %b want 1", bus.spawn_ready); end
        step();
        clear_inputs();
        n_cmp++; if (bus.miss !== 4'b0001) begin n_bad++; $display("FAIL miss_pulse got %b want 0001", bus.miss); end
        step();
        n_cmp++; if (bus.miss !== 4'b0000) begin n_bad++; $display("FAIL miss_pulse_end got %b want 0000", bus.miss); end
        probe(10'd10, 10'd15);
        n_cmp++; if (bus.pix_on !== 1'b1) begin n_bad++; $display("FAIL miss_new_y0_top got %b want 1", bus.pix_on); end
        probe(10'd10, 10'd16);
        n_cmp++; if (bus.pix_on !== 1'b0) begin n_bad++; $display("FAIL miss_new_y0_end got %b want 0", bus.pix_on); end
        probe(10'd10, 10'd479);
        n_cmp++; if (bus.pix_on !== 1'b0) begin n_bad++; $display("FAIL miss_old_gone got %b want 0", bus.pix_on); end
    endtask

    task automatic test_saturate();
        do_reset();
        spawn(4'b1111);
        frames(220);
        strike(4'b1111);
        n_cmp++; if (bus.hit_ok !== 4'b1111) begin n_bad++; $display("FAIL multi_hit_ok got %b want 1111", bus.hit_ok); end
        n_cmp++; if (bus.score !== 16'd4) begin n_bad++; $display("FAIL multi_score got %0d want 4", bus.score); end
        n_cmp++; if (bus2.hit_ok !== 4'b1111) begin n_bad++; $display("FAIL sat_hit_ok got %b want 1111", bus2.hit_ok); end
        n_cmp++; if (bus2.score !== 16'hFFFF) begin n_bad++; $display("FAIL sat_score got %h want ffff", bus2.score); end
        strike(4'b1111);
        n_cmp++; if (bus2.hit_bad !== 4'b1111) begin n_bad++; $display("FAIL sat_hit_bad got %b want 1111", bus2.hit_bad); end
        n_cmp++; if (bus2.score !== 16'hFFFF) begin n_bad++; $display("FAIL sat_score_hold got %h want ffff", bus2.score); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_spawn_pixel();
        test_fill();
        test_hit();
        test_window();
        test_miss();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
